online_select_residue: RTL and testbench

- Sequential selection and residue stage of the radix-2 online multiplier.
- Sits directly downstream of the signed-digit parallel adder. Each step it consumes the adder's redundant sum, selects one output digit in {-1,0,+1}, and registers the shifted residue. That residue is fed back to the adder's residue inputs for the next step.
- Owns step sequencing: the online-delay warm-up phase, digit counting and the done pulse.

---
 rtl/online_select_residue.sv | 159 +++++++++++++++
 tb/tb_online_select_residue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/online_select_residue.sv
// Selection and residue stage of the radix-2 online multiplier: picks one digit in {-1,0,+1}
// per accepted step from the adder's redundant sum and registers the doubled residue.
module online_select_residue #(
   parameter int BITS  = 8,
   parameter int NDIG  = 8,
   parameter int DELTA = 3,
   parameter int CW    = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            in_valid,
   input  logic [BITS-1:0] sum_plus,
   input  logic [BITS-1:0] sum_minus,
   input  logic            cout_err,
   output logic [BITS-1:0] residue_plus,
   output logic [BITS-1:0] residue_minus,
   output logic            z_plus,
   output logic            z_minus,
   output logic            z_valid,
   output logic [CW-1:0]   digit_idx,
   output logic            busy,
   output logic            done,
   output logic            ovf
);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

   localparam int HALF = 2 ** (BITS - 2);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          r_digit_idx;
   logic [BITS-1:0]        r_res_p;
   logic [BITS-1:0]        r_res_m;
   logic                   r_zp;
   logic                   r_zm;
   logic                   r_zv;
   logic                   r_done;
   logic                   r_ovf;

   logic                   w_busy;
   logic                   w_accept;
   logic                   w_start_acc;
   logic                   w_is_run;
   logic signed [BITS:0]   w_sum;
   logic signed [4:0]      w_est;
   logic                   w_sel_p;
   logic                   w_sel_m;
   logic signed [BITS+1:0] w_zterm;
   logic signed [BITS+1:0] w_diff;
   logic signed [BITS+2:0] w_rnext;
   logic                   w_rng_ovf;
   logic [BITS-1:0]        w_rt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (start) w_state_nxt = S_INIT;
         S_INIT: if (in_valid && r_cnt == CW'(DELTA - 1)) w_state_nxt = S_RUN;
         S_RUN:  if (in_valid && r_cnt == CW'(NDIG - 1)) w_state_nxt = S_DONE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State-decoded controls
   always_comb begin
      w_busy      = 1'b0;
      w_is_run    = 1'b0;
      w_start_acc = 1'b0;
      case (r_state)
         S_IDLE: w_start_acc = start;
         S_INIT: w_busy = 1'b1;
         S_RUN: begin
            w_busy   = 1'b1;
            w_is_run = 1'b1;
         end
         default: ;
      endcase
      w_accept = w_busy & in_valid;
   end

   // Top four digit positions weigh 8/4/2/1, so E is the difference of the two nibbles
   assign w_sum   = $signed({1'b0, sum_plus}) - $signed({1'b0, sum_minus});
   assign w_est   = $signed({1'b0, sum_plus[BITS-1:BITS-4]}) - $signed({1'b0, sum_minus[BITS-1:BITS-4]});
   assign w_sel_p = w_is_run && (w_est >= 5'sd2);
   assign w_sel_m = w_is_run && (w_est <= -5'sd3);

   always_comb begin
      w_zterm = '0;
      if (w_sel_p)      w_zterm = (BITS+2)'(HALF);
      else if (w_sel_m) w_zterm = -(BITS+2)'(HALF);
   end

   assign w_diff    = {w_sum[BITS], w_sum} - w_zterm;
   assign w_rnext   = {w_diff, 1'b0};
   // In range iff every bit from BITS-1 upward is a copy of the sign
   assign w_rng_ovf = !((&w_rnext[BITS+2:BITS-1]) || (~|w_rnext[BITS+2:BITS-1]));
   assign w_rt      = w_rnext[BITS-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_digit_idx <= '0;
         r_res_p     <= '0;
         r_res_m     <= '0;
         r_zp        <= 1'b0;
         r_zm        <= 1'b0;
         r_zv        <= 1'b0;
         r_done      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_zp   <= 1'b0;
         r_zm   <= 1'b0;
         r_zv   <= 1'b0;
         r_done <= (r_state == S_DONE);
         if (w_start_acc) begin
            r_cnt       <= '0;
            r_digit_idx <= '0;
            r_res_p     <= '0;
            r_res_m     <= '0;
            r_ovf       <= 1'b0;
         end else if (w_accept) begin
            r_res_p <= {1'b0, w_rt[BITS-2:0]};
            r_res_m <= {w_rt[BITS-1], {(BITS-1){1'b0}}};
            if (w_rng_ovf || cout_err) r_ovf <= 1'b1;
            if (w_is_run) begin
               r_zv        <= 1'b1;
               r_zp        <= w_sel_p;
               r_zm        <= w_sel_m;
               r_digit_idx <= r_cnt;
               r_cnt       <= (r_cnt == CW'(NDIG - 1)) ? '0 : r_cnt + 1'b1;
            end else begin
               r_cnt       <= (r_cnt == CW'(DELTA - 1)) ? '0 : r_cnt + 1'b1;
            end
         end
      end
   end

   assign residue_plus  = r_res_p;
   assign residue_minus = r_res_m;
   assign z_plus        = r_zp;
   assign z_minus       = r_zm;
   assign z_valid       = r_zv;
   assign digit_idx     = r_digit_idx;
   assign busy          = w_busy;
   assign done          = r_done;
   assign ovf           = r_ovf;

endmodule

// File: tb/tb_online_select_residue.sv
// Scoreboard bench for online_select_residue: driver pushes model-predicted digits and residues,
// a negedge monitor pops and compares whenever z_valid or done is presented.
module tb_online_select_residue;

   localparam int BITS  = 8;
   localparam int NDIG  = 8;
   localparam int DELTA = 3;
   localparam int CW    = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            in_valid = 1'b0;
   logic [BITS-1:0] sum_plus = '0;
   logic [BITS-1:0] sum_minus = '0;
   logic            cout_err = 1'b0;
   logic [BITS-1:0] residue_plus, residue_minus;
   logic            z_plus, z_minus, z_valid, busy, done, ovf;
   logic [CW-1:0]   digit_idx;

   online_select_residue #(.BITS(BITS), .NDIG(NDIG), .DELTA(DELTA), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .sum_plus(sum_plus), .sum_minus(sum_minus), .cout_err(cout_err),
      .residue_plus(residue_plus), .residue_minus(residue_minus),
      .z_plus(z_plus), .z_minus(z_minus), .z_valid(z_valid),
      .digit_idx(digit_idx), .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            zp;
      logic            zm;
      int              idx;
      logic [BITS-1:0] rp;
      logic [BITS-1:0] rm;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   bit   sb_en = 1'b1;
   bit   prev_final = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Arithmetic reference: values as plain integers in units of 2^-(BITS-2)
   function automatic void model(input logic [BITS-1:0] sp, input logic [BITS-1:0] sm, input bit run,
                                 output bit zp, output bit zm, output logic [BITS-1:0] rp,
                                 output logic [BITS-1:0] rm, output bit o);
      int s, e, z, r;
      logic [BITS-1:0] t;
      s = int'(sp) - int'(sm);
      e = int'(sp >> (BITS - 4)) - int'(sm >> (BITS - 4));
      z = 0;
      if (run) z = (e >= 2) ? 1 : ((e <= -3) ? -1 : 0);
      r = (s - z * (1 << (BITS - 2))) * 2;
      o = (r < -(1 << (BITS - 1))) || (r > (1 << (BITS - 1)) - 1);
      t = r[BITS-1:0];
      zp = (z == 1);
      zm = (z == -1);
      rp = {1'b0, t[BITS-2:0]};
      rm = {t[BITS-1], {(BITS-1){1'b0}}};
   endfunction

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (sb_en && rst_n) begin
         if (z_valid) begin
            if (q.size() == 0) begin
               chk("z_unexpected", 32'(z_valid), 32'(0));
            end else begin
               e = q.pop_front();
               chk("z_plus", 32'(z_plus), 32'(e.zp));
               chk("z_minus", 32'(z_minus), 32'(e.zm));
               chk("digit_idx", 32'(digit_idx), 32'(e.idx));
               chk("residue_plus", 32'(residue_plus), 32'(e.rp));
               chk("residue_minus", 32'(residue_minus), 32'(e.rm));
            end
         end
         if (done || prev_final) chk("done_after_last", 32'(done), 32'(prev_final));
         prev_final = z_valid && (digit_idx == CW'(NDIG - 1));
      end
   end

   logic [BITS-1:0] d_sp[6] = '{8'h20, 8'h00, 8'h10, 8'h00, 8'h7F, 8'h00};
   logic [BITS-1:0] d_sm[6] = '{8'h00, 8'h28, 8'h00, 8'h20, 8'h00, 8'h00};
   bit              d_ce[6] = '{0, 0, 0, 0, 0, 1};

   // vmode: 0 always valid, 1 toggle, 2 random; directed: use d_* table for the first RUN steps
   task automatic run_op(input int vmode, input bit directed, input bit noise);
      int acc, k, cyc;
      bit v, eo, zp, zm, o;
      logic [BITS-1:0] rp, rm;
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      acc = 0; k = 0; cyc = 0; eo = 1'b0;
      while (acc < DELTA + NDIG) begin
         chk("busy_in_op", 32'(busy), 32'(1));
         chk("ovf_sticky", 32'(ovf), 32'(eo));
         case (vmode)
            0: v = 1'b1;
            1: v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         if (directed && acc < DELTA) begin
            sum_plus = '0; sum_minus = '0; cout_err = 1'b0;
         end else if (directed && k < 6) begin
            sum_plus = d_sp[k]; sum_minus = d_sm[k]; cout_err = d_ce[k];
         end else begin
            sum_plus = BITS'($urandom); sum_minus = BITS'($urandom);
            cout_err = ($urandom_range(0, 15) == 0);
         end
         in_valid = v;
         start = noise && ($urandom_range(0, 5) == 0);
         if (v) begin
            model(sum_plus, sum_minus, acc >= DELTA, zp, zm, rp, rm, o);
            eo = eo | o | cout_err;
            if (acc >= DELTA) begin
               e.zp = zp; e.zm = zm; e.idx = k; e.rp = rp; e.rm = rm;
               q.push_back(e);
               k++;
            end
            acc++;
         end
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start = 1'b0;
      cout_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("busy_after_op", 32'(busy), 32'(0));
      chk("ovf_after_op", 32'(ovf), 32'(eo));
      chk("queue_drained", 32'(q.size()), 32'(0));
      q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_zvalid", 32'(z_valid), 32'(0));
      chk("reset_res_p", 32'(residue_plus), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_op(0, 1'b1, 1'b0);
      run_op(1, 1'b0, 1'b1);
      run_op(1, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) run_op($urandom_range(0, 2), 1'b0, 1'b1);

      // Asynchronous abort in the middle of RUN with ovf already set
      sb_en = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      sum_plus = 8'h20;
      sum_minus = 8'h00;
      cout_err = 1'b1;
      repeat (DELTA + 2) @(negedge clk);
      cout_err = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_zvalid", 32'(z_valid), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_ovf", 32'(ovf), 32'(0));
      chk("abort_res", 32'({residue_plus, residue_minus}), 32'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
      prev_final = 1'b0;
      sb_en = 1'b1;
      run_op(0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
